// File: rtl/mem_access_pkg.sv
// Shared widths, operation encoding, FSM state type and operation classifiers
// for the memory-stage data-bus master.
package mem_access_pkg;

   localparam int unsigned W_OPER = 4;
   localparam int unsigned W_ADDR = 32;
   localparam int unsigned W_DATA = 32;

   // MEM-stage operation encoding; anything not listed is a non-memory op
   typedef enum logic [W_OPER-1:0] {
      OperNop = 4'd0,
      OperLb  = 4'd1,
      OperLbu = 4'd2,
      OperLh  = 4'd3,
      OperLhu = 4'd4,
      OperLw  = 4'd5,
      OperSb  = 4'd6,
      OperSh  = 4'd7,
      OperSw  = 4'd8,
      OperAlu = 4'd9
   } oper_e;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StDone,
      StDrain
   } mem_state_t;

   typedef enum logic [1:0] {
      SizeByte,
      SizeHalf,
      SizeWord,
      SizeNone
   } size_e;

   function automatic logic is_oper_ld(input logic [W_OPER-1:0] op);
      return (op == OperLb) || (op == OperLbu) || (op == OperLh) ||
             (op == OperLhu) || (op == OperLw);
   endfunction

   function automatic logic is_oper_st(input logic [W_OPER-1:0] op);
      return (op == OperSb) || (op == OperSh) || (op == OperSw);
   endfunction

   function automatic logic is_oper_mm(input logic [W_OPER-1:0] op);
      return is_oper_ld(op) || is_oper_st(op);
   endfunction

   function automatic size_e oper_size(input logic [W_OPER-1:0] op);
      size_e sz;
      case (op)
         OperLb, OperLbu, OperSb: sz = SizeByte;
         OperLh, OperLhu, OperSh: sz = SizeHalf;
         OperLw, OperSw:          sz = SizeWord;
         default:                 sz = SizeNone;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mem_access_store_fmt.sv
// Combinational store formatting: lane replication, byte strobes and the
// natural-alignment check for half and word accesses.
module mem_store_fmt
   import mem_access_pkg::*;
(
   input  logic [W_OPER-1:0] oper_i,
   input  logic [1:0]        offset_i,
   input  logic [W_DATA-1:0] st_data_i,
   output logic [W_DATA-1:0] wdata_o,
   output logic [3:0]        wstrb_o,
   output logic              misaligned_o
);

   // Loads keep all strobes set; stores narrow them to the addressed lanes
   always_comb begin
      wdata_o      = st_data_i;
      wstrb_o      = 4'b1111;
      misaligned_o = 1'b0;
      case (oper_size(oper_i))
         SizeByte: begin
            if (is_oper_st(oper_i)) begin
               wdata_o = {4{st_data_i[7:0]}};
               wstrb_o = 4'b0001 << offset_i;
            end
         end
         SizeHalf: begin
            misaligned_o = offset_i[0];
            if (is_oper_st(oper_i)) begin
               wdata_o = {2{st_data_i[15:0]}};
               wstrb_o = offset_i[1] ? 4'b1100 : 4'b0011;
            end
         end
         SizeWord: misaligned_o = (offset_i != 2'b00);
         default:  ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-stage data-bus master: issues one word-aligned access at a time,
// stalls the pipeline while it is outstanding and hands the raw word onward.
module mem_access
   import mem_access_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [W_OPER-1:0] oper,
   input  logic              valid,
   input  logic              flush,
   input  logic              hold,
   input  logic [W_ADDR-1:0] addr,
   input  logic [W_DATA-1:0] st_data,
   output logic              data_req,
   output logic              data_wr,
   output logic [3:0]        data_wstrb,
   output logic [W_ADDR-1:0] data_addr,
   output logic [W_DATA-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [W_DATA-1:0] data_rdata,
   output logic [1:0]        word_offset,
   output logic [W_DATA-1:0] rd_data_b,
   output logic              mem_stall,
   output logic              adel,
   output logic              ades
);

   mem_state_t        state_q, state_d;
   logic [W_DATA-1:0] data_q, data_d;
   logic              misaligned;
   logic              act;
   logic              complete;

   mem_store_fmt u_store_fmt (
      .oper_i       (oper),
      .offset_i     (addr[1:0]),
      .st_data_i    (st_data),
      .wdata_o      (data_wdata),
      .wstrb_o      (data_wstrb),
      .misaligned_o (misaligned)
   );

   // Request attributes and exception flags follow the MEM-stage inputs directly
   always_comb begin
      act         = valid & is_oper_mm(oper) & ~flush & ~misaligned;
      data_wr     = is_oper_st(oper);
      data_addr   = {addr[W_ADDR-1:2], 2'b00};
      word_offset = addr[1:0];
      adel        = valid & ~flush & is_oper_ld(oper) & misaligned;
      ades        = valid & ~flush & is_oper_st(oper) & misaligned;
   end

   // Handshake sequencing, stall generation and data capture
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      data_req  = 1'b0;
      mem_stall = 1'b0;
      complete  = 1'b0;
      case (state_q)
         StIdle: begin
            data_req = act;
            if (act) begin
               if (data_addr_ok && data_data_ok) complete = 1'b1;
               else if (data_addr_ok)             state_d  = StWait;
               else                               state_d  = StReq;
               mem_stall = ~complete;
            end
         end
         StReq: begin
            data_req = 1'b1;
            if (flush)                              state_d  = StIdle;
            else if (data_addr_ok && data_data_ok)  complete = 1'b1;
            else if (data_addr_ok)                  state_d  = StWait;
            mem_stall = ~complete;
         end
         StWait: begin
            // A flush that coincides with the response still completes normally
            if (data_data_ok) complete = 1'b1;
            else if (flush)   state_d  = StDrain;
            mem_stall = ~complete;
         end
         StDone: begin
            if (!hold) state_d = StIdle;
         end
         StDrain: begin
            // The discarded response must not let a waiting op slip past unissued
            mem_stall = 1'b1;
            if (data_data_ok) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (complete) begin
         data_d  = data_rdata;
         state_d = hold ? StDone : StIdle;
      end
   end

   // Raw load word: frozen copy while the pipeline is held, live bus otherwise
   always_comb begin
      rd_data_b = (state_q == StDone) ? data_q : data_rdata;
   end

   // State and captured-word registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a transaction-level model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk, rst;
   logic [3:0]  oper;
   logic        valid, flush, hold;
   logic [31:0] addr, st_data;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [1:0]  word_offset;
   logic [31:0] rd_data_b;
   logic        mem_stall, adel, ades;

   int n_checks = 0;
   int n_errors = 0;

   // Model: what the outstanding transaction is doing, and the held word
   logic        m_unaccepted, m_awaiting, m_discarding, m_frozen;
   logic [31:0] m_word;

   mem_access dut (
      .clk          (clk),
      .rst          (rst),
      .oper         (oper),
      .valid        (valid),
      .flush        (flush),
      .hold         (hold),
      .addr         (addr),
      .st_data      (st_data),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .word_offset  (word_offset),
      .rd_data_b    (rd_data_b),
      .mem_stall    (mem_stall),
      .adel         (adel),
      .ades         (ades)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model; inputs are stable at the falling edge
   always @(negedge clk) begin
      logic        mis, is_ld, is_st, act, idle, done_now, exp_stall;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      if (rst) begin
         m_unaccepted <= 1'b0;
         m_awaiting   <= 1'b0;
         m_discarding <= 1'b0;
         m_frozen     <= 1'b0;
         m_word       <= '0;
      end else begin
         is_ld = (oper == OperLb) || (oper == OperLbu) || (oper == OperLh) ||
                 (oper == OperLhu) || (oper == OperLw);
         is_st = (oper == OperSb) || (oper == OperSh) || (oper == OperSw);
         case (oper)
            OperLh, OperLhu, OperSh: mis = addr[0];
            OperLw, OperSw:          mis = (addr[1:0] != 2'b00);
            default:                 mis = 1'b0;
         endcase
         case (oper)
            OperSb:  begin exp_strb = 4'b0001 << addr[1:0];
                           exp_wdata = {4{st_data[7:0]}}; end
            OperSh:  begin exp_strb = addr[1] ? 4'b1100 : 4'b0011;
                           exp_wdata = {2{st_data[15:0]}}; end
            default: begin exp_strb = 4'b1111; exp_wdata = st_data; end
         endcase
         act  = valid && (is_ld || is_st) && !flush && !mis;
         idle = !(m_unaccepted || m_awaiting || m_discarding || m_frozen);
         done_now = (idle && act && data_addr_ok && data_data_ok) ||
                    (m_unaccepted && !flush && data_addr_ok && data_data_ok) ||
                    (m_awaiting && data_data_ok);
         if (m_discarding)                  exp_stall = 1'b1;
         else if (m_unaccepted || m_awaiting) exp_stall = !done_now;
         else if (idle)                     exp_stall = act && !done_now;
         else                               exp_stall = 1'b0;

         check("model_req", {31'd0, data_req}, {31'd0, idle ? act : m_unaccepted});
         check("model_stall", {31'd0, mem_stall}, {31'd0, exp_stall});
         check("model_rd", rd_data_b, m_frozen ? m_word : data_rdata);
         check("model_adel", {31'd0, adel}, {31'd0, valid && !flush && is_ld && mis});
         check("model_ades", {31'd0, ades}, {31'd0, valid && !flush && is_st && mis});
         check("model_addr", data_addr, {addr[31:2], 2'b00});
         check("model_wr", {31'd0, data_wr}, {31'd0, is_st});
         check("model_off", {30'd0, word_offset}, {30'd0, addr[1:0]});
         check("model_strb", {28'd0, data_wstrb}, {28'd0, exp_strb});
         if (is_st) check("model_wdata", data_wdata, exp_wdata);

         if (done_now) begin
            m_word       <= data_rdata;
            m_frozen     <= hold;
            m_unaccepted <= 1'b0;
            m_awaiting   <= 1'b0;
         end else if (idle && act) begin
            m_unaccepted <= !data_addr_ok;
            m_awaiting   <= data_addr_ok;
         end else if (m_unaccepted) begin
            if (flush) m_unaccepted <= 1'b0;
            else if (data_addr_ok) begin
               m_unaccepted <= 1'b0;
               m_awaiting   <= 1'b1;
            end
         end else if (m_awaiting) begin
            if (flush) begin
               m_awaiting   <= 1'b0;
               m_discarding <= 1'b1;
            end
         end else if (m_discarding) begin
            if (data_data_ok) m_discarding <= 1'b0;
         end else if (m_frozen) begin
            if (!hold) m_frozen <= 1'b0;
         end
      end
   end

   task automatic drv(input logic [3:0] op, input logic v, input logic fl, input logic hd,
                      input logic [31:0] a, input logic [31:0] sd, input logic aok,
                      input logic dok, input logic [31:0] rd);
      oper = op; valid = v; flush = fl; hold = hd; addr = a; st_data = sd;
      data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      drv(OperNop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      drv(OperNop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("rst_req", {31'd0, data_req}, 32'd0);
      check("rst_stall", {31'd0, mem_stall}, 32'd0);
      check("rst_adel", {31'd0, adel}, 32'd0);
      check("rst_ades", {31'd0, ades}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      idle_cycle();

      // LW 0x100: accepted at once, response two cycles later
      drv(OperLw, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
      check("lw_c0_req", {31'd0, data_req}, 32'd1);
      check("lw_c0_stall", {31'd0, mem_stall}, 32'd1);
      tick();
      drv(OperLw, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
      check("lw_c1_stall", {31'd0, mem_stall}, 32'd1);
      check("lw_c1_req", {31'd0, data_req}, 32'd0);
      tick();
      drv(OperLw, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
      check("lw_c2_stall", {31'd0, mem_stall}, 32'd0);
      check("lw_c2_rd", rd_data_b, 32'hDEADBEEF);
      check("lw_c2_off", {30'd0, word_offset}, 32'd0);
      tick();
      idle_cycle();

      // SB 0x103: zero-latency store on the top lane
      drv(OperSb, 1'b1, 1'b0, 1'b0, 32'h103, 32'h12, 1'b1, 1'b1, 32'h0);
      check("sb_strb", {28'd0, data_wstrb}, 32'h8);
      check("sb_wdata", data_wdata, 32'h12121212);
      check("sb_addr", data_addr, 32'h100);
      check("sb_wr", {31'd0, data_wr}, 32'd1);
      check("sb_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      // SH 0x106: upper half lanes
      drv(OperSh, 1'b1, 1'b0, 1'b0, 32'h106, 32'hABCD1234, 1'b1, 1'b1, 32'h0);
      check("sh_strb", {28'd0, data_wstrb}, 32'hC);
      check("sh_wdata", data_wdata, 32'h12341234);
      tick();

      // Misaligned accesses raise flags without bus activity
      drv(OperLh, 1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 1'b0, 1'b0, 32'h0);
      check("lh_adel", {31'd0, adel}, 32'd1);
      check("lh_req", {31'd0, data_req}, 32'd0);
      check("lh_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      drv(OperSw, 1'b1, 1'b0, 1'b0, 32'h102, 32'h5, 1'b0, 1'b0, 32'h0);
      check("sw_ades", {31'd0, ades}, 32'd1);
      check("sw_req", {31'd0, data_req}, 32'd0);
      tick();
      idle_cycle();

      // Flush while the request is still unaccepted drops it
      drv(OperLw, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
      check("req_c0_req", {31'd0, data_req}, 32'd1);
      tick();
      drv(OperLw, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drv(OperNop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("req_c2_req", {31'd0, data_req}, 32'd0);
      check("req_c2_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      drv(OperLw, 1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 1'b1, 1'b1, 32'h0BADF00D);
      check("req_c3_req", {31'd0, data_req}, 32'd1);
      check("req_c3_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      idle_cycle();

      // Flush while awaiting data: response drained, next op waits for it
      drv(OperLw, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      drv(OperLw, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
      check("drn_c1_stall", {31'd0, mem_stall}, 32'd1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drv(OperLbu, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 1'b0, 1'b0, 32'h0);
         check("drn_wait_req", {31'd0, data_req}, 32'd0);
         check("drn_wait_stall", {31'd0, mem_stall}, 32'd1);
         tick();
      end
      drv(OperLbu, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 1'b0, 1'b1, 32'hAAAAAAAA);
      check("drn_c4_stall", {31'd0, mem_stall}, 32'd1);
      check("drn_c4_req", {31'd0, data_req}, 32'd0);
      tick();
      drv(OperLbu, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 1'b1, 1'b1, 32'h11223344);
      check("drn_c5_req", {31'd0, data_req}, 32'd1);
      check("drn_c5_addr", data_addr, 32'h204);
      check("drn_c5_stall", {31'd0, mem_stall}, 32'd0);
      check("drn_c5_rd", rd_data_b, 32'h11223344);
      tick();
      idle_cycle();

      // Completion under hold: captured word survives bus changes
      drv(OperLw, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D);
      check("hold_c0_stall", {31'd0, mem_stall}, 32'd0);
      check("hold_c0_rd", rd_data_b, 32'hCAFEF00D);
      tick();
      drv(OperLw, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0);
      check("hold_c1_rd", rd_data_b, 32'hCAFEF00D);
      check("hold_c1_req", {31'd0, data_req}, 32'd0);
      check("hold_c1_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      drv(OperLw, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h55555555);
      check("hold_c2_rd", rd_data_b, 32'hCAFEF00D);
      check("hold_c2_req", {31'd0, data_req}, 32'd0);
      tick();
      drv(OperNop, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h00000077);
      check("hold_c3_rd", rd_data_b, 32'h00000077);
      tick();
      idle_cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage data-bus master for the MIPS pipeline. It decodes load and store operations into word-aligned data-bus transactions with byte strobes and detects misaligned accesses. It sequences the bus handshake and stalls the pipeline while an access is outstanding. It hands the raw bus word (`rd_data_b`) and byte offset (`word_offset`) to the writeback stage, which performs sign/zero extension and byte selection.

## Interface
Parameters:
- none; widths come from `W_OPER`, `W_ADDR`, `W_DATA` in `defines.vh`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `oper`  in  `W_OPER`  MEM-stage operation; memory op when `IS_OPER_MM(oper)`.
- `valid`  in  1  MEM-stage instruction is valid.
- `flush`  in  1  kill the MEM-stage instruction.
- `hold`  in  1  downstream freeze; the pipeline does not advance this cycle.
- `addr`  in  `W_ADDR`  effective address.
- `st_data`  in  `W_DATA`  store source register value.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  1 = write.
- `data_wstrb`  out  4  byte strobes; all ones for loads.
- `data_addr`  out  `W_ADDR`  `{addr[31:2],2'b00}`.
- `data_wdata`  out  `W_DATA`  lane-replicated store data.
- `data_addr_ok`  in  1  request accepted.
- `data_data_ok`  in  1  response or write completion.
- `data_rdata`  in  `W_DATA`  read word.
- `word_offset`  out  2  `addr[1:0]`, passed to writeback.
- `rd_data_b`  out  `W_DATA`  raw load word for writeback.
- `mem_stall`  out  1  freeze the pipeline.
- `adel`, `ades`  out  1  load / store address-error flags.

## Operation
- Access: `act = valid & IS_OPER_MM(oper) & !flush & !misaligned`.
- Misalignment:
  - LH/LHU/SH are misaligned when `addr[0]=1`.
  - LW/SW are misaligned when `addr[1:0]!=0`.
  - Byte ops are never misaligned.
  - A misaligned op raises `adel` (load) or `ades` (store) combinationally, issues no request and produces no stall.
- Store formatting:
  - SB: data `{4{st_data[7:0]}}`, strobe `4'b0001<<addr[1:0]`.
  - SH: data `{2{st_data[15:0]}}`, strobe `addr[1] ? 4'b1100 : 4'b0011`.
  - SW: data `st_data`, strobe `4'b1111`.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE: `data_req = act`.
    - `act & addr_ok & data_ok`: complete, go to DONE if `hold`, else stay IDLE.
    - `act & addr_ok`: go to WAIT.
    - `act & !addr_ok`: go to REQ.
  - REQ: `data_req = 1` with outputs stable.
    - `flush`: go to IDLE and drop the request.
    - `addr_ok & data_ok`: complete, same branch as IDLE.
    - `addr_ok`: go to WAIT.
  - WAIT: `data_req = 0`.
    - `flush & !data_ok`: go to DRAIN.
    - `data_ok`: complete.
  - DONE: hold the captured word; go to IDLE when `!hold`.
  - DRAIN: wait for `data_ok`, discard the response, then go to IDLE.
- `rd_data_b`: the registered word in DONE, otherwise `data_rdata`.
- The data register captures `data_rdata` on every completion.
- `mem_stall` is 1 when either:
  - state is REQ, WAIT or DRAIN and there is no completion this cycle, or
  - state is IDLE, `act` is set and there is no same-cycle completion.
- `mem_stall` is 0 in DONE.

## Timing
- Reset values: state IDLE, data register 0, `data_req`/`mem_stall`/`adel`/`ades` 0.
- Reset mid-transaction abandons it; the bus is required to drop any pending `data_ok` on `rst`.
- Minimum latency: zero stall cycles when `addr_ok` and `data_ok` arrive in the issue cycle.
- Typical latency: issue at cycle 0 and `addr_ok` at cycle 0 → WAIT at cycle 1; `data_ok` at cycle N → stall low at cycle N and data valid at cycle N.
- At most one outstanding transaction; no request is issued in WAIT, DRAIN or DONE.
- `flush` in the same cycle as `data_ok` in WAIT counts as a completion; the data is discarded by the pipeline and the FSM does not enter DRAIN.
- A flush in DRAIN has no further effect.
- A new op presented during DRAIN is stalled until DRAIN exits, then issued from IDLE.

## Structure
- Add to `defines.vh`:
  - the `mem_state_t` encoding for the five states;
  - the `IS_OPER_LD` / `IS_OPER_ST` macros;
  - the size class macros (byte / half / word).
- Sub-module `mem_store_fmt`: combinational store lane replication, strobe generation and misalignment check.
- The FSM, data register and stall logic stay in `mem_access`.

## Test plan
- LW to `0x100`, `addr_ok` cycle 0, `data_ok` cycle 2 with `0xDEADBEEF` → stall high cycles 0-1; cycle 2: `rd_data_b=0xDEADBEEF`, `word_offset=0`.
- SB to `0x103`, `st_data=0x12` → `data_wstrb=4'b1000`, `data_wdata=0x12121212`, `data_addr=0x100`, `data_wr=1`.
- LH to `0x101` → `adel=1`, `data_req=0`, `mem_stall=0`; SW to `0x102` → `ades=1`.
- LW with `addr_ok` delayed 3 cycles, `flush` in cycle 1 → `data_req` low from cycle 2, FSM in IDLE.
- LW in WAIT, `flush` in cycle 1, `data_ok` in cycle 4 → DRAIN; a following LBU at `0x204` issues in cycle 5.
- `data_ok` with `hold=1` for 2 cycles, bus `data_rdata` changed afterwards → `rd_data_b` keeps the captured word through DONE; returns to IDLE when `hold` drops.
